// File: rtl/rvv_backend_uop_queue.sv
// Uop queue between decode control and dispatch: up to 4 in-order pushes and
// up to 2 pops per cycle, with exact-match occupancy flags for decode throttling.
`ifndef UQ_WIDTH
`define UQ_WIDTH 32
`endif

module rvv_backend_uop_queue #(
    parameter int DEPTH       = 16,
    parameter int DEPTH_WIDTH = $clog2(DEPTH),
    parameter int WIDTH       = `UQ_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0,
    input  logic             push1,
    input  logic             push2,
    input  logic             push3,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic             fifo_full,
    output logic             fifo_1left_to_full,
    output logic             fifo_2left_to_full,
    output logic             fifo_3left_to_full,
    input  logic             pop0,
    input  logic             pop1,
    output logic             uop_valid0,
    output logic             uop_valid1,
    output logic [WIDTH-1:0] uop0,
    output logic [WIDTH-1:0] uop1,
    output logic             fifo_empty,
    output logic             push_err,
    output logic             pop_err
);

    localparam logic [DEPTH_WIDTH:0] CNT_FULL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] CNT_1L   = (DEPTH_WIDTH+1)'(DEPTH - 1);
    localparam logic [DEPTH_WIDTH:0] CNT_2L   = (DEPTH_WIDTH+1)'(DEPTH - 2);
    localparam logic [DEPTH_WIDTH:0] CNT_3L   = (DEPTH_WIDTH+1)'(DEPTH - 3);
    localparam logic [DEPTH_WIDTH:0] CNT_ONE  = (DEPTH_WIDTH+1)'(1);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH:0]   count;

    logic [3:0]             push_vec;
    logic [WIDTH-1:0]       data_lane [4];
    logic                   push_legal;
    logic [2:0]             npush;
    logic [DEPTH_WIDTH:0]   free;
    logic                   push_ok;
    logic [2:0]             push_acc;
    logic [1:0]             pop_acc;
    logic                   pop_bad;

    assign push_vec     = {push3, push2, push1, push0};
    assign data_lane[0] = data0;
    assign data_lane[1] = data1;
    assign data_lane[2] = data2;
    assign data_lane[3] = data3;

    always_comb begin
        push_legal = 1'b1;
        npush      = 3'd0;
        case (push_vec)
            4'b0000: npush = 3'd0;
            4'b0001: npush = 3'd1;
            4'b0011: npush = 3'd2;
            4'b0111: npush = 3'd3;
            4'b1111: npush = 3'd4;
            default: push_legal = 1'b0;
        endcase
    end

    // Free space uses the start-of-cycle count; same-cycle pops never make room.
    assign free     = CNT_FULL - count;
    assign push_ok  = push_legal && ((DEPTH_WIDTH+1)'(npush) <= free);
    assign push_acc = push_ok ? npush : 3'd0;

    always_comb begin
        pop_acc = 2'd0;
        pop_bad = 1'b0;
        if (pop1 && !pop0) begin
            pop_bad = 1'b1;
        end else if (pop0) begin
            if (count == '0) begin
                pop_bad = 1'b1;
            end else if (pop1 && count == CNT_ONE) begin
                pop_acc = 2'd1;
                pop_bad = 1'b1;
            end else begin
                pop_acc = pop1 ? 2'd2 : 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            push_err <= 1'b0;
            pop_err  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + DEPTH_WIDTH'(pop_acc);
            wr_ptr <= wr_ptr + DEPTH_WIDTH'(push_acc);
            count  <= count + (DEPTH_WIDTH+1)'(push_acc) - (DEPTH_WIDTH+1)'(pop_acc);
            if (|push_vec && !push_ok) push_err <= 1'b1;
            if (pop_bad)               pop_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && push_ok) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (push_vec[k]) mem[wr_ptr + DEPTH_WIDTH'(k)] <= data_lane[k];
            end
        end
    end

    assign uop0 = mem[rd_ptr];
    assign uop1 = mem[rd_ptr + DEPTH_WIDTH'(1)];

    assign fifo_empty         = (count == '0);
    assign uop_valid0         = (count != '0);
    assign uop_valid1         = (count > CNT_ONE);
    assign fifo_full          = (count == CNT_FULL);
    assign fifo_1left_to_full = (count == CNT_1L);
    assign fifo_2left_to_full = (count == CNT_2L);
    assign fifo_3left_to_full = (count == CNT_3L);

endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// Directed self-checking bench for rvv_backend_uop_queue (DEPTH=16, WIDTH=32).
module tb_rvv_backend_uop_queue;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         push0 = 1'b0, push1 = 1'b0, push2 = 1'b0, push3 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
    logic         pop0 = 1'b0, pop1 = 1'b0;
    logic         fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full;
    logic         uop_valid0, uop_valid1, fifo_empty, push_err, pop_err;
    logic [W-1:0] uop0, uop1;

    int n_chk  = 0;
    int n_fail = 0;

    rvv_backend_uop_queue #(.DEPTH(16), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .push0(push0), .push1(push1), .push2(push2), .push3(push3),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .fifo_full(fifo_full), .fifo_1left_to_full(fifo_1left_to_full),
        .fifo_2left_to_full(fifo_2left_to_full), .fifo_3left_to_full(fifo_3left_to_full),
        .pop0(pop0), .pop1(pop1),
        .uop_valid0(uop_valid0), .uop_valid1(uop_valid1),
        .uop0(uop0), .uop1(uop1),
        .fifo_empty(fifo_empty), .push_err(push_err), .pop_err(pop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected flags derived from the bench's own occupancy count.
    task automatic chk_status(input string tag, input int cnt);
        chk({tag, ":empty"},  W'(fifo_empty),         W'(cnt == 0));
        chk({tag, ":valid0"}, W'(uop_valid0),         W'(cnt >= 1));
        chk({tag, ":valid1"}, W'(uop_valid1),         W'(cnt >= 2));
        chk({tag, ":full"},   W'(fifo_full),          W'(cnt == 16));
        chk({tag, ":1left"},  W'(fifo_1left_to_full), W'(cnt == 15));
        chk({tag, ":2left"},  W'(fifo_2left_to_full), W'(cnt == 14));
        chk({tag, ":3left"},  W'(fifo_3left_to_full), W'(cnt == 13));
    endtask

    task automatic cyc(input logic [3:0] pv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic p0, input logic p1);
        {push3, push2, push1, push0} = pv;
        data0 = a; data1 = b; data2 = c; data3 = d;
        pop0 = p0; pop1 = p1;
        @(posedge clk);
        #1;
        {push3, push2, push1, push0} = 4'b0000;
        pop0 = 1'b0; pop1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        cyc(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_status("reset", 0);
        chk("reset:push_err", W'(push_err), '0);
        chk("reset:pop_err",  W'(pop_err),  '0);

        // Four-lane push into empty queue
        cyc(4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0, 1'b0);
        chk_status("push4", 4);
        chk("push4:uop0", uop0, 32'hA);
        chk("push4:uop1", uop1, 32'hB);

        // Fill to 13, then 16, then an overflow push
        cyc(4'b1111, 32'h10, 32'h11, 32'h12, 32'h13, 1'b0, 1'b0);
        cyc(4'b1111, 32'h14, 32'h15, 32'h16, 32'h17, 1'b0, 1'b0);
        cyc(4'b0001, 32'h18, '0, '0, '0, 1'b0, 1'b0);
        chk_status("fill13", 13);
        cyc(4'b0111, 32'h19, 32'h1A, 32'h1B, '0, 1'b0, 1'b0);
        chk_status("fill16", 16);
        chk("fill16:push_err", W'(push_err), '0);
        cyc(4'b0001, 32'hEE, '0, '0, '0, 1'b0, 1'b0);
        chk_status("overflow", 16);
        chk("overflow:push_err", W'(push_err), 1);
        chk("overflow:uop0", uop0, 32'hA);

        // Double pop with one entry, then pop on empty
        do_reset();
        cyc(4'b0001, 32'h55, '0, '0, '0, 1'b0, 1'b0);
        chk_status("one", 1);
        chk("one:uop0", uop0, 32'h55);
        cyc(4'b0000, '0, '0, '0, '0, 1'b1, 1'b1);
        chk_status("pop2of1", 0);
        chk("pop2of1:pop_err", W'(pop_err), 1);
        chk("pop2of1:push_err", W'(push_err), 0);
        cyc(4'b0000, '0, '0, '0, '0, 1'b1, 1'b0);
        chk_status("pop_empty", 0);
        chk("pop_empty:pop_err", W'(pop_err), 1);

        // pop1 without pop0 is ignored
        do_reset();
        cyc(4'b0011, 32'h61, 32'h62, '0, '0, 1'b0, 1'b0);
        cyc(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1);
        chk_status("pop1only", 2);
        chk("pop1only:pop_err", W'(pop_err), 1);
        chk("pop1only:uop0", uop0, 32'h61);

        // count=15, push 2 + pop 2 in the same cycle
        do_reset();
        cyc(4'b1111, 32'h100, 32'h101, 32'h102, 32'h103, 1'b0, 1'b0);
        cyc(4'b1111, 32'h104, 32'h105, 32'h106, 32'h107, 1'b0, 1'b0);
        cyc(4'b1111, 32'h108, 32'h109, 32'h10A, 32'h10B, 1'b0, 1'b0);
        cyc(4'b0011, 32'h10C, 32'h10D, '0, '0, 1'b0, 1'b0);
        chk_status("fill14", 14);
        cyc(4'b0001, 32'h10E, '0, '0, '0, 1'b0, 1'b0);
        chk_status("fill15", 15);
        cyc(4'b0011, 32'hF0, 32'hF1, '0, '0, 1'b1, 1'b1);
        chk_status("pushpop15", 13);
        chk("pushpop15:push_err", W'(push_err), 1);
        chk("pushpop15:pop_err",  W'(pop_err),  0);
        chk("pushpop15:uop0", uop0, 32'h102);
        chk("pushpop15:uop1", uop1, 32'h103);

        // Steady-state push 1 / pop 1 across the pointer wrap
        do_reset();
        cyc(4'b0011, 32'h200, 32'h201, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("wrap:uop0_pre", uop0, W'(32'h200 + i));
            cyc(4'b0001, W'(32'h202 + i), '0, '0, '0, 1'b1, 1'b0);
            chk("wrap:uop0", uop0, W'(32'h201 + i));
            chk("wrap:uop1", uop1, W'(32'h202 + i));
            chk("wrap:valid1", W'(uop_valid1), 1);
        end
        chk("wrap:push_err", W'(push_err), 0);
        chk("wrap:pop_err",  W'(pop_err),  0);

        // Illegal push pattern, then reset mid-stream (push in the reset cycle is ignored)
        do_reset();
        cyc(4'b0101, 32'h31, 32'h32, 32'h33, 32'h34, 1'b0, 1'b0);
        chk_status("illegal", 0);
        chk("illegal:push_err", W'(push_err), 1);
        cyc(4'b1111, 32'h40, 32'h41, 32'h42, 32'h43, 1'b0, 1'b0);
        cyc(4'b1111, 32'h44, 32'h45, 32'h46, 32'h47, 1'b0, 1'b0);
        cyc(4'b0001, 32'h48, '0, '0, '0, 1'b0, 1'b0);
        chk_status("nine", 9);
        chk("nine:uop0", uop0, 32'h40);
        rst_n = 1'b1;
        cyc(4'b1111, 32'h50, 32'h51, 32'h52, 32'h53, 1'b1, 1'b1);
        rst_n = 1'b0;
        chk_status("midreset", 0);
        chk("midreset:push_err", W'(push_err), 0);
        chk("midreset:pop_err",  W'(pop_err),  0);
        cyc(4'b0001, 32'h77, '0, '0, '0, 1'b0, 1'b0);
        chk_status("post_reset", 1);
        chk("post_reset:uop0", uop0, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
